// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
package fifo_pkg;

  localparam int FIFO_DATA_W_DEF = 16;
  localparam int FIFO_DEPTH_DEF  = 8;

  // Index width for a power-of-two depth; never narrower than one bit.
  function automatic int fifo_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Simple dual-port storage: one write port, one registered read port.
// The array itself is never reset; only the read register clears.
module fifo_mem_2p #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdata_r;

  // Storage write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read register holds its value when no read is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_r <= {DATA_W{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count and threshold flags.
// Define SYNC_FIFO_ERR_EN to build the sticky overflow/underflow flags.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = FIFO_DATA_W_DEF,
  parameter int DEPTH     = FIFO_DEPTH_DEF,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           w_en,
  input  logic [DATA_W-1:0]              data_in,
  input  logic                           r_en,
  output logic [DATA_W-1:0]              data_out,
  output logic                           rd_valid,
  output logic                           full,
  output logic                           empty,
  output logic                           almost_full,
  output logic                           almost_empty,
  output logic [fifo_addr_w(DEPTH):0]    count,
  output logic                           overflow,
  output logic                           underflow
);

  localparam int ADDR_W = fifo_addr_w(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [CNT_W-1:0] wptr_r;
  logic [CNT_W-1:0] rptr_r;
  logic [CNT_W-1:0] count_r;
  logic             rd_valid_r;
  logic             wr_acc_s;
  logic             rd_acc_s;

  // Acceptance uses the registered flags only; no same-cycle bypass.
  assign wr_acc_s = w_en && !full;
  assign rd_acc_s = r_en && !empty;

  assign full         = (count_r == CNT_W'(DEPTH));
  assign empty        = (count_r == {CNT_W{1'b0}});
  assign almost_full  = (count_r >= CNT_W'(AFULL_TH));
  assign almost_empty = (count_r <= CNT_W'(AEMPTY_TH));
  assign count        = count_r;
  assign rd_valid     = rd_valid_r;

  // Pointer, occupancy and read-strobe state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_r     <= {CNT_W{1'b0}};
      rptr_r     <= {CNT_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      rd_valid_r <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wptr_r <= wptr_r + CNT_W'(1);
      end
      if (rd_acc_s) begin
        rptr_r <= rptr_r + CNT_W'(1);
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      rd_valid_r <= rd_acc_s;
    end
  end

  fifo_mem_2p #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc_s && rst_n),
    .waddr (wptr_r[ADDR_W-1:0]),
    .wdata (data_in),
    .re    (rd_acc_s && rst_n),
    .raddr (rptr_r[ADDR_W-1:0]),
    .rdata (data_out)
  );

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_r;
  logic underflow_r;

  // Sticky error flags; any rejected-while-full/empty request latches them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= overflow_r  || (w_en && full);
      underflow_r <= underflow_r || (r_en && empty);
    end
  end

  assign overflow  = overflow_r;
  assign underflow = underflow_r;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed scoreboard bench for sync_fifo_param (DATA_W=16, DEPTH=8, AFULL_TH=6, AEMPTY_TH=2).
module tb_sync_fifo_param;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        w_en = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic        r_en = 1'b0;
  logic [15:0] data_out;
  logic        rd_valid;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic [3:0]  count;
  logic        overflow;
  logic        underflow;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] sb_q[$];
  logic [15:0] exp_dout = 16'h0000;
  logic        exp_valid = 1'b0;
  logic        exp_ovf = 1'b0;
  logic        exp_unf = 1'b0;

  sync_fifo_param #(
    .DATA_W(16), .DEPTH(DEPTH), .AFULL_TH(6), .AEMPTY_TH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(data_out), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = sb_q.size();
    chk({tag, " count"}, 32'(count), 32'(n));
    chk({tag, " empty"}, 32'(empty), 32'(n == 0));
    chk({tag, " full"}, 32'(full), 32'(n == DEPTH));
    chk({tag, " almost_full"}, 32'(almost_full), 32'(n >= 6));
    chk({tag, " almost_empty"}, 32'(almost_empty), 32'(n <= 2));
    chk({tag, " rd_valid"}, 32'(rd_valid), 32'(exp_valid));
    chk({tag, " data_out"}, 32'(data_out), 32'(exp_dout));
    chk({tag, " overflow"}, 32'(overflow), 32'(exp_ovf));
    chk({tag, " underflow"}, 32'(underflow), 32'(exp_unf));
  endtask

  // One clock: drive, update scoreboard with pre-edge occupancy, then check after the edge.
  task automatic step(input string tag, input logic w, input logic [15:0] d,
                      input logic r, input logic rst);
    bit full_m;
    bit empty_m;
    full_m  = (sb_q.size() == DEPTH);
    empty_m = (sb_q.size() == 0);
    w_en    = w;
    data_in = d;
    r_en    = r;
    rst_n   = ~rst;
    @(posedge clk);
    if (rst) begin
      sb_q.delete();
      exp_dout  = 16'h0000;
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
      exp_unf   = 1'b0;
    end else begin
      exp_valid = 1'b0;
      if (r && !empty_m) begin
        exp_dout  = sb_q.pop_front();
        exp_valid = 1'b1;
      end
      if (w && !full_m) sb_q.push_back(d);
`ifdef SYNC_FIFO_ERR_EN
      if (w && full_m) exp_ovf = 1'b1;
      if (r && empty_m) exp_unf = 1'b1;
`endif
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    step("reset", 1'b0, 16'h0000, 1'b0, 1'b1);
    step("reset2", 1'b1, 16'h1234, 1'b1, 1'b1);
    step("idle", 1'b0, 16'h0000, 1'b0, 1'b0);

    for (int i = 1; i <= 8; i++) step("fill", 1'b1, 16'(i), 1'b0, 1'b0);
    step("overfill", 1'b1, 16'hDEAD, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) step("drain", 1'b0, 16'h0000, 1'b1, 1'b0);
    step("overdrain", 1'b0, 16'h0000, 1'b1, 1'b0);
    step("idle2", 1'b0, 16'h0000, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) step("prefill4", 1'b1, 16'h0A00 + 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step("stream", 1'b1, 16'h0100 + 16'(i), 1'b1, 1'b0);

    for (int i = 0; i < 4; i++) step("tofull", 1'b1, 16'h0B00 + 16'(i), 1'b0, 1'b0);
    step("full_wr_rd", 1'b1, 16'hBAD0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step("drain7", 1'b0, 16'h0000, 1'b1, 1'b0);
    step("empty_wr_rd", 1'b1, 16'h0C0C, 1'b1, 1'b0);
    step("read_one", 1'b0, 16'h0000, 1'b1, 1'b0);

    for (int i = 0; i < 5; i++) step("to5", 1'b1, 16'h0D00 + 16'(i), 1'b0, 1'b0);
    step("mid_reset", 1'b1, 16'hFEED, 1'b0, 1'b1);
    step("post_reset_rd", 1'b0, 16'h0000, 1'b1, 1'b0);
    step("post_reset_wr", 1'b1, 16'hBEEF, 1'b0, 1'b0);
    step("post_reset_rd2", 1'b0, 16'h0000, 1'b1, 1'b0);
    step("final_idle", 1'b0, 16'h0000, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO, the successor to the fixed 16-bit × 8 synchronous FIFO. It buffers data between a producer and a consumer in the same clock domain. It adds configurable width and depth, an occupancy count, programmable almost-full/almost-empty flags and a read-valid strobe. Optional sticky overflow/underflow error flags are compiled in by macro.

## Interface
Parameters:
- DATA_W, 16, data word width (≥1)
- DEPTH, 8, number of entries; power of two, ≥2
- AFULL_TH, 6, almost_full asserts when count ≥ AFULL_TH (1..DEPTH)
- AEMPTY_TH, 2, almost_empty asserts when count ≤ AEMPTY_TH (0..DEPTH-1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- w_en  in  1  write request
- data_in  in  DATA_W  write data
- r_en  in  1  read request
- data_out  out  DATA_W  read data, registered
- rd_valid  out  1  data_out updated this cycle
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AFULL_TH
- almost_empty  out  1  count ≤ AEMPTY_TH
- count  out  ADDR_W+1  occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- ADDR_W = $clog2(DEPTH). Write and read pointers are ADDR_W+1 bits; the MSB is the wrap bit. Memory is indexed by the low ADDR_W bits.
- Write accepted when w_en && !full: mem[wptr] ← data_in, wptr+1.
- Read accepted when r_en && !empty: data_out ← mem[rptr], rptr+1, rd_valid=1 next cycle. Otherwise rd_valid=0 and data_out holds its value.
- full/empty are the values at the start of the cycle (registered state). There is no same-cycle bypass.
  - Full with w_en && r_en: only the read is accepted, count → DEPTH-1.
  - Empty with w_en && r_en: only the write is accepted, count → 1.
- Otherwise a simultaneous accepted read and write leaves count unchanged.
- count is a register: +1 on write-only, −1 on read-only, unchanged otherwise. It must always equal wptr−rptr (mod 2^(ADDR_W+1)).
- All flags are decoded combinationally from the count register.
- Pointers wrap naturally from all ones to zero. After wrap, full ⇔ MSBs differ and low bits are equal.
- Rejected requests are silently dropped and do not change state (except error flags, see Configuration).

## Timing
- Write-to-read latency: data written at edge N is readable (empty=0) from edge N+1. The earliest read-accept edge is N+1, and data_out/rd_valid are visible after that edge.
- Read latency: one cycle from the accepting edge to data_out.
- Flags and count reflect all transfers accepted at the previous edge.
- Reset (rst_n=0 at an edge) sets:
  - pointers=0, count=0
  - data_out=0, rd_valid=0
  - empty=1, full=0, almost_empty=1
  - almost_full=0
  - overflow=0, underflow=0
- Reset wins over any w_en/r_en in the same cycle. Reset mid-operation discards all contents.
- Memory array is not reset; stale contents are never observable.

## Configuration
- SYNC_FIFO_ERR_EN defined: overflow sets on any cycle with w_en && full; underflow sets on any cycle with r_en && empty. Both are sticky until reset.
- SYNC_FIFO_ERR_EN undefined: overflow and underflow ports remain and are tied to 0. No error logic is generated.

## Structure
- Package fifo_pkg holds:
  - the clog2-based width helper function
  - default parameter constants (FIFO_DATA_W_DEF=16, FIFO_DEPTH_DEF=8)
- Sub-module fifo_mem_2p: simple dual-port memory with one write port and one registered read port (DATA_W × DEPTH, no reset). The top holds the pointers, count, flags and error logic.

## Test plan
(DATA_W=16, DEPTH=8, AFULL_TH=6, AEMPTY_TH=2 unless stated)
- Reset then idle → empty=1, almost_empty=1, count=0, data_out=0, rd_valid=0.
- Write 0x0001..0x0008 back-to-back → full=1 after the 8th edge, almost_full=1 from count=6. A 9th write (0xDEAD) is dropped, and overflow=1 with SYNC_FIFO_ERR_EN, else 0.
- Drain 8 reads → data_out 0x0001..0x0008 in order, each with rd_valid=1. A 9th read sets underflow (macro on), data_out holds 0x0008, and empty=1.
- Continuous simultaneous write/read at count=4 for 20 cycles (pointer wrap) → count stays 4, and output order matches input order.
- Full + w_en&&r_en → read accepted, write dropped, count=7. Empty + w_en&&r_en → write accepted, rd_valid=0, count=1.
- Assert rst_n=0 for one cycle at count=5 with w_en=1 → count=0, empty=1, flags cleared, and the write is discarded.
